icache_miss_controller: RTL

Sequences instruction fetch around the I-cache. On a miss it freezes the PC register by driving its stall/hit control, then bursts the missing line from instruction memory one word per handshake and writes each word into the cache data array. It raises the line-valid/tag write, then releases the PC. It sits between the PC register, the I-cache arrays and the memory port.

---
 rtl/icache_miss_controller_pkg.sv | 24 ++
 rtl/icache_miss_controller_if.sv | 46 ++++
 rtl/icache_miss_controller_burst_counter.sv | 50 +++++
 rtl/icache_miss_controller.sv | 101 ++++++++++
 4 files changed

// File: rtl/icache_miss_controller_pkg.sv
// icache_miss_controller shared types and helpers.
// Optional build macro: ICACHE_CRITICAL_WORD_FIRST_EN.
package icache_miss_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WORDS_PER_LINE_DEF = 4;

  function automatic int word_off_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int WORD_OFF_W = word_off_w(WORDS_PER_LINE_DEF);

  // Clears the word offset and byte offset bits of a line.
  function automatic logic [63:0] line_mask(input int words);
    return ~((64'd1 << (word_off_w(words) + 2)) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_miss_controller_if.sv
// Fetch, memory and fill signals of the I-cache miss controller.
// master = controller side, slave = PC/cache/memory side.
interface icache_miss_controller_if
  import icache_miss_controller_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
);
  localparam int OW = word_off_w(WORDS_PER_LINE);

  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              cache_hit;
  logic              pc_hold;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              fill_we;
  logic [OW-1:0]     fill_word;
  logic [31:0]       fill_data;
  logic              fill_done;
  logic [ADDR_W-1:0] line_addr;
  logic              busy;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    input  fetch_valid, fetch_addr, cache_hit,
    input  mem_ready, mem_rdata,
    output pc_hold, mem_req, mem_addr,
    output fill_we, fill_word, fill_data,
    output fill_done, line_addr, busy,
    output miss_count
  );

  modport slave (
    output fetch_valid, fetch_addr, cache_hit,
    output mem_ready, mem_rdata,
    input  pc_hold, mem_req, mem_addr,
    input  fill_we, fill_word, fill_data,
    input  fill_done, line_addr, busy,
    input  miss_count
  );

endinterface

// File: rtl/icache_miss_controller_burst_counter.sv
// Wrapping word-offset counter for a line burst,
// with a beat counter that flags the final beat.
module icache_burst_counter
  import icache_miss_controller_pkg::*;
#(
  parameter int WORDS = 4,
  localparam int OW = word_off_w(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [OW-1:0] start_i,
  input  logic          inc_i,
  output logic [OW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [OW-1:0] LAST = OW'(WORDS - 1);

  logic [OW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] beat_q, beat_d;

  // Load start offset on a new miss, advance on each beat.
  always_comb begin
    cnt_d  = cnt_q;
    beat_d = beat_q;
    if (load_i) begin
      cnt_d  = start_i;
      beat_d = '0;
    end else if (inc_i) begin
      cnt_d  = cnt_q + OW'(1);
      beat_d = beat_q + OW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      beat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (beat_q == LAST);

endmodule

// File: rtl/icache_miss_controller.sv
// I-cache miss sequencer: holds the PC, bursts a line, marks it valid.
// Build macro ICACHE_CRITICAL_WORD_FIRST_EN starts at the missed word.
module icache_miss_controller
  import icache_miss_controller_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 32
) (
  input logic clk,
  input logic rst,
  icache_miss_controller_if.master bus
);

  localparam int OW = word_off_w(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] MASK =
    ADDR_W'(line_mask(WORDS_PER_LINE));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic          miss;
  logic          beat;
  logic          load;
  logic          last;
  logic [OW-1:0] cnt;
  logic [OW-1:0] start;

  assign miss = bus.fetch_valid & ~bus.cache_hit;
  assign beat = (state_q == REQ) & bus.mem_ready;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign start = bus.fetch_addr[OW+1:2];
`else
  assign start = '0;
`endif

  icache_burst_counter #(
    .WORDS (WORDS_PER_LINE)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .start_i (start),
    .inc_i   (beat),
    .cnt_o   (cnt),
    .last_o  (last)
  );

  // Next state, line latch and miss counter update.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    miss_d  = miss_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = REQ;
          line_d  = bus.fetch_addr & MASK;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (beat && last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.pc_hold    = (state_q != IDLE) | miss;
  assign bus.mem_req    = (state_q == REQ);
  assign bus.mem_addr   = (state_q == REQ) ?
                          line_q + (ADDR_W'(cnt) << 2) : '0;
  assign bus.fill_we    = beat;
  assign bus.fill_word  = (state_q == REQ) ? cnt : '0;
  assign bus.fill_data  = bus.mem_rdata;
  assign bus.fill_done  = (state_q == DONE);
  assign bus.line_addr  = line_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.miss_count = miss_q;

endmodule
